// File: rtl/decode_if.sv
// Handshake and bus bundle between fetch, decode, execute and writeback.
// The master side drives IF_ID, the stall and flush controls, and writeback.
interface decode_if;
  logic [63:0]  IF_ID;
  logic         if_valid;
  logic         id_ready;
  logic         ex_ready;
  logic         flush;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic [138:0] ID_EX;
  logic         id_valid;

  modport master (
    output IF_ID, if_valid, ex_ready, flush,
    output wb_en, wb_addr, wb_data,
    input  id_ready, ID_EX, id_valid
  );

  modport slave (
    input  IF_ID, if_valid, ex_ready, flush,
    input  wb_en, wb_addr, wb_data,
    output id_ready, ID_EX, id_valid
  );
endinterface

// File: rtl/decode.sv
// Instruction decode stage: field split, 32x32 regfile, load-use bubble.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module decode #(
  parameter logic [5:0] LW_OP  = 6'h23,
  parameter logic [5:0] SW_OP  = 6'h2B,
  parameter logic [5:0] BEQ_OP = 6'h04
) (
  input logic     clock,
  input logic     reset,
  decode_if.slave bus
);

  logic [31:0]  rf_q [32];
  logic [31:0]  rf_d [32];
  logic [138:0] id_ex_q, id_ex_d;
  logic         id_valid_q, id_valid_d;

  logic [31:0]  pc, inst, imm, rs_val, rt_val;
  logic [5:0]   opcode;
  logic [4:0]   rs, rt, rd, dest;
  logic [138:0] word;
  logic         hazard;
  logic         wb_hit;

  assign pc     = bus.IF_ID[63:32];
  assign inst   = bus.IF_ID[31:0];
  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign imm    = {{16{inst[15]}}, inst[15:0]};
  assign wb_hit = bus.wb_en && (bus.wb_addr != 5'd0);

  // Destination register select by instruction class.
  always_comb begin
    dest = rt;
    if (opcode == 6'd0)
      dest = rd;
    else if (opcode == SW_OP || opcode == BEQ_OP)
      dest = 5'd0;
  end

  // Regfile read ports, optionally forwarding same-cycle writeback.
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && bus.wb_addr == rs)
      rs_val = bus.wb_data;
    if (wb_hit && bus.wb_addr == rt)
      rt_val = bus.wb_data;
`endif
  end

  assign word = {opcode, dest, imm, rt_val, rs_val, pc};

  // Load-use: a valid load in ID_EX targets a source of IF_ID.
  always_comb begin
    hazard = id_valid_q
          && (id_ex_q[138:133] == LW_OP)
          && (id_ex_q[132:128] != 5'd0)
          && (id_ex_q[132:128] == rs
           || id_ex_q[132:128] == rt);
  end

  assign bus.id_ready = bus.flush || (bus.ex_ready && !hazard);

  // Regfile next state; index 0 is never written.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit)
      rf_d[bus.wb_addr] = bus.wb_data;
  end

  // ID_EX next state: flush, stall, bubble, issue, idle.
  always_comb begin
    id_ex_d    = id_ex_q;
    id_valid_d = id_valid_q;
    if (bus.flush) begin
      id_ex_d    = '0;
      id_valid_d = 1'b0;
    end else if (!bus.ex_ready) begin
      id_ex_d    = id_ex_q;
      id_valid_d = id_valid_q;
    end else if (hazard) begin
      id_valid_d = 1'b0;
    end else if (bus.if_valid) begin
      id_ex_d    = word;
      id_valid_d = 1'b1;
    end else begin
      id_valid_d = 1'b0;
    end
  end

  // Register file state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Pipeline register toward execute.
  always_ff @(posedge clock) begin
    if (!reset) begin
      id_ex_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      id_ex_q    <= id_ex_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.ID_EX    = id_ex_q;
  assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage.
// Expected values are hand-derived from the instruction encodings.
module tb_decode;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int errs   = 0;
  int checks = 0;

  decode_if dif ();

  decode dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [138:0] act,
                     input logic [138:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(
    input logic [4:0] rs, rt, rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rs, rt,
    input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    dif.wb_en   = 1'b1;
    dif.wb_addr = a;
    dif.wb_data = d;
    step();
    dif.wb_en   = 1'b0;
  endtask

  logic [31:0] pc_f, rs_f, rt_f, imm_f;
  logic [4:0]  dst_f;
  logic [5:0]  op_f;
  always_comb begin
    pc_f  = dif.ID_EX[31:0];
    rs_f  = dif.ID_EX[63:32];
    rt_f  = dif.ID_EX[95:64];
    imm_f = dif.ID_EX[127:96];
    dst_f = dif.ID_EX[132:128];
    op_f  = dif.ID_EX[138:133];
  end

  logic [31:0] byp_exp;

  initial begin
    dif.IF_ID    = '0;
    dif.if_valid = 1'b0;
    dif.ex_ready = 1'b1;
    dif.flush    = 1'b0;
    dif.wb_en    = 1'b0;
    dif.wb_addr  = '0;
    dif.wb_data  = '0;

    step();
    step();
    chk("rst_valid", dif.id_valid, 0);
    chk("rst_idex", dif.ID_EX, 0);

    reset = 1'b1;
    wr(5'd1, 32'd5);
    wr(5'd2, 32'd7);

    dif.IF_ID    = {32'h4, rtype(5'd1, 5'd2, 5'd3)};
    dif.if_valid = 1'b1;
    step();
    chk("r_valid", dif.id_valid, 1);
    chk("r_pc", pc_f, 32'h4);
    chk("r_rs", rs_f, 32'd5);
    chk("r_rt", rt_f, 32'd7);
    chk("r_dest", dst_f, 5'd3);
    chk("r_imm", imm_f, 32'h1800);

    dif.IF_ID = {32'h8, itype(6'h23, 5'd1, 5'd4, 16'hFFFC)};
    step();
    chk("lw_valid", dif.id_valid, 1);
    chk("lw_imm", imm_f, 32'hFFFF_FFFC);
    chk("lw_dest", dst_f, 5'd4);
    chk("lw_op", op_f, 6'h23);

    dif.IF_ID = {32'hC, rtype(5'd4, 5'd1, 5'd5)};
    #1;
    chk("hz_ready", dif.id_ready, 0);
    step();
    chk("hz_bubble", dif.id_valid, 0);
    chk("hz_ready2", dif.id_ready, 1);
    step();
    chk("hz_issue", dif.id_valid, 1);
    chk("hz_pc", pc_f, 32'hC);
    chk("hz_dest", dst_f, 5'd5);
    chk("hz_rt", rt_f, 32'd5);

    dif.IF_ID    = {32'h10, rtype(5'd2, 5'd1, 5'd6)};
    dif.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_ready", dif.id_ready, 0);
      step();
      chk("st_valid", dif.id_valid, 1);
      chk("st_pc", pc_f, 32'hC);
    end
    dif.ex_ready = 1'b1;
    step();
    chk("st_adv_pc", pc_f, 32'h10);
    chk("st_adv_rs", rs_f, 32'd7);
    chk("st_adv_dest", dst_f, 5'd6);

    dif.IF_ID = {32'h14, itype(6'h2B, 5'd1, 5'd2, 16'h8)};
    dif.flush = 1'b1;
    #1;
    chk("fl_ready", dif.id_ready, 1);
    step();
    chk("fl_valid", dif.id_valid, 0);
    dif.flush = 1'b0;
    step();
    chk("sw_valid", dif.id_valid, 1);
    chk("sw_dest", dst_f, 5'd0);
    chk("sw_op", op_f, 6'h2B);
    chk("sw_pc", pc_f, 32'h14);

    dif.IF_ID = {32'h18, itype(6'h04, 5'd1, 5'd2, 16'h3)};
    step();
    chk("beq_dest", dst_f, 5'd0);

    dif.if_valid = 1'b0;
    wr(5'd0, 32'hDEAD);
    chk("idle_valid", dif.id_valid, 0);
    dif.IF_ID    = {32'h1C, rtype(5'd0, 5'd0, 5'd7)};
    dif.if_valid = 1'b1;
    step();
    chk("r0_rs", rs_f, 32'd0);

    dif.if_valid = 1'b0;
    wr(5'd5, 32'd1);
    dif.IF_ID    = {32'h20, rtype(5'd5, 5'd0, 5'd8)};
    dif.if_valid = 1'b1;
    dif.wb_en    = 1'b1;
    dif.wb_addr  = 5'd5;
    dif.wb_data  = 32'd9;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'd9;
`else
    byp_exp = 32'd1;
`endif
    step();
    dif.wb_en = 1'b0;
    chk("byp_rs", rs_f, byp_exp);
    step();
    chk("after_wb_rs", rs_f, 32'd9);

    dif.ex_ready = 1'b0;
    reset = 1'b0;
    step();
    chk("mrst_valid", dif.id_valid, 0);
    chk("mrst_idex", dif.ID_EX, 0);
    reset        = 1'b1;
    dif.ex_ready = 1'b1;
    dif.IF_ID    = {32'h24, rtype(5'd1, 5'd5, 5'd9)};
    step();
    chk("mrst_r1", rs_f, 32'd0);
    chk("mrst_r5", rt_f, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
